control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Instruction decode sequencer: registered control word, multi-cycle MAC hold,
// HALT/resume, flush and stall handling, and a saturating illegal-opcode counter.
module control_sequencer #(
   parameter int OP_W       = 4,
   parameter int ALU_W      = 3,
   parameter int MAC_CYCLES = 2,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 instr_valid,
   input  logic [OP_W-1:0]      opcode,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 resume,
   output logic                 RegWrite,
   output logic                 MemtoReg,
   output logic                 MemWrite,
   output logic                 MemRead,
   output logic                 ALUSrc,
   output logic                 RegDst,
   output logic [ALU_W-1:0]     ALUControl1,
   output logic [ALU_W-1:0]     ALUControl2,
   output logic                 PCEn,
   output logic                 ctrl_valid,
   output logic                 halted,
   output logic                 illegal_op,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MAC_BUSY = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   typedef struct packed {
      logic             reg_write;
      logic             mem_to_reg;
      logic             mem_write;
      logic             mem_read;
      logic             alu_src;
      logic             reg_dst;
      logic [ALU_W-1:0] alu1;
      logic [ALU_W-1:0] alu2;
   } ctrl_t;

   localparam logic [3:0] MAC_LOAD = 4'(MAC_CYCLES - 1);

   state_t               r_state, w_state_nxt;
   ctrl_t                r_ctrl, w_ctrl_nxt, w_dec, w_nop;
   logic                 r_cv, w_cv_nxt;
   logic                 r_pc, w_pc_nxt;
   logic                 r_ill, w_ill_nxt;
   logic [ERR_CNT_W-1:0] r_err, w_err_nxt;
   logic [3:0]           r_cnt, w_cnt_nxt;
   logic                 w_legal, w_is_halt, w_is_mac, w_upper_zero;

   assign w_upper_zero = ((opcode >> 4) == '0);

   always_comb begin
      w_nop            = '0;
      w_nop.mem_to_reg = 1'b1;
      w_nop.alu1       = '1;
      w_nop.alu2       = '1;
   end

   // Every legal opcode starts from the NOP word and overrides only its own fields.
   always_comb begin
      w_dec     = w_nop;
      w_legal   = w_upper_zero;
      w_is_halt = 1'b0;
      w_is_mac  = 1'b0;
      case (opcode[3:0])
         4'b0000: ;
         4'b0001: begin
            w_dec.reg_write = 1'b1;
            w_dec.reg_dst   = 1'b1;
            w_dec.alu1      = ALU_W'(0);
         end
         4'b1001: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.alu1      = ALU_W'(0);
         end
         4'b0010: begin
            w_dec.reg_write = 1'b1;
            w_dec.reg_dst   = 1'b1;
            w_dec.alu1      = ALU_W'(1);
         end
         4'b0011: begin
            w_dec.reg_write = 1'b1;
            w_dec.reg_dst   = 1'b1;
            w_dec.alu1      = ALU_W'(2);
         end
         4'b0100: begin
            w_dec.reg_write = 1'b1;
            w_dec.reg_dst   = 1'b1;
            w_dec.alu1      = ALU_W'(1);
            w_dec.alu2      = ALU_W'(0);
            w_is_mac        = w_upper_zero;
         end
         4'b1110: begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = 1'b0;
            w_dec.mem_read   = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.alu1       = ALU_W'(0);
         end
         4'b1111: begin
            w_dec.mem_write  = 1'b1;
            w_dec.mem_to_reg = 1'b0;
            w_dec.alu_src    = 1'b1;
            w_dec.alu1       = ALU_W'(0);
         end
         4'b1011: w_is_halt = w_upper_zero;
         default: w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         w_dec = w_nop;
      end
   end

   // Priority: flush, then stall (hold), then state-specific behaviour.
   // illegal_op is a pulse, so it drops on every edge that is not a fresh illegal decode.
   always_comb begin
      w_state_nxt = r_state;
      w_ctrl_nxt  = r_ctrl;
      w_cv_nxt    = r_cv;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      w_ill_nxt   = 1'b0;
      w_err_nxt   = r_err;
      if (flush) begin
         w_ctrl_nxt = w_nop;
         w_cv_nxt   = 1'b0;
         if (r_state == ST_HALTED) begin
            w_pc_nxt = 1'b0;
         end else begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = 1'b1;
            w_cnt_nxt   = 4'd0;
         end
      end else if (!stall) begin
         case (r_state)
            ST_RUN: begin
               w_ctrl_nxt = w_nop;
               w_cv_nxt   = 1'b0;
               w_pc_nxt   = 1'b1;
               if (instr_valid) begin
                  if (!w_legal) begin
                     w_ill_nxt = 1'b1;
                     if (r_err != '1) begin
                        w_err_nxt = r_err + ERR_CNT_W'(1);
                     end
                  end else if (w_is_halt) begin
                     w_state_nxt = ST_HALTED;
                     w_pc_nxt    = 1'b0;
                  end else begin
                     w_ctrl_nxt = w_dec;
                     w_cv_nxt   = 1'b1;
                     if (w_is_mac && (MAC_CYCLES > 1)) begin
                        w_state_nxt = ST_MAC_BUSY;
                        w_cnt_nxt   = MAC_LOAD;
                        w_pc_nxt    = 1'b0;
                     end
                  end
               end
            end
            ST_MAC_BUSY: begin
               if (r_cnt <= 4'd1) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = 4'd0;
                  w_pc_nxt    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
                  w_pc_nxt  = 1'b0;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  w_state_nxt = ST_RUN;
                  w_pc_nxt    = 1'b1;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
         r_ctrl  <= w_nop;
         r_cv    <= 1'b0;
         r_pc    <= 1'b1;
         r_cnt   <= 4'd0;
         r_ill   <= 1'b0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ctrl  <= w_ctrl_nxt;
         r_cv    <= w_cv_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ill   <= w_ill_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign RegWrite    = r_ctrl.reg_write;
   assign MemtoReg    = r_ctrl.mem_to_reg;
   assign MemWrite    = r_ctrl.mem_write;
   assign MemRead     = r_ctrl.mem_read;
   assign ALUSrc      = r_ctrl.alu_src;
   assign RegDst      = r_ctrl.reg_dst;
   assign ALUControl1 = r_ctrl.alu1;
   assign ALUControl2 = r_ctrl.alu2;
   assign PCEn        = r_pc & ~stall;
   assign ctrl_valid  = r_cv;
   assign halted      = (r_state == ST_HALTED);
   assign illegal_op  = r_ill;
   assign err_count   = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized and directed bench for control_sequencer against a table-driven
// behavioural model of the sequencer rules.
module tb_control_sequencer;

   localparam int OP_W       = 5;
   localparam int ALU_W      = 3;
   localparam int MAC_CYCLES = 3;
   localparam int ERR_CNT_W  = 8;
   localparam int ERR_MAX    = 255;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic instr_valid = 1'b0;
   logic [OP_W-1:0] opcode = '0;
   logic stall = 1'b0;
   logic flush = 1'b0;
   logic resume = 1'b0;
   logic RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst;
   logic [ALU_W-1:0] ALUControl1, ALUControl2;
   logic PCEn, ctrl_valid, halted, illegal_op;
   logic [ERR_CNT_W-1:0] err_count;
   logic [1:0] o_dbg_state;

   int n_checks = 0;
   int n_fail = 0;

   control_sequencer #(
      .OP_W(OP_W), .ALU_W(ALU_W), .MAC_CYCLES(MAC_CYCLES), .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .opcode(opcode),
      .stall(stall), .flush(flush), .resume(resume),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
      .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUControl1(ALUControl1), .ALUControl2(ALUControl2),
      .PCEn(PCEn), .ctrl_valid(ctrl_valid), .halted(halted), .illegal_op(illegal_op),
      .err_count(err_count), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   // Control word layout: {RegWrite,MemtoReg,MemWrite,MemRead,ALUSrc,RegDst,ALU1,ALU2}.
   logic [11:0] tab [16];
   bit          legal [16];
   localparam int OPC_MAC  = 4;
   localparam int OPC_HALT = 11;

   logic [11:0] m_ctrl;
   bit          m_cv, m_halted, m_ill, m_pc;
   int          m_err, m_busy;

   function automatic logic [11:0] mk(input bit rw, mtr, mw, mr, as, rd, input int a1, a2);
      return {rw, mtr, mw, mr, as, rd, 3'(a1), 3'(a2)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ctrl = tab[0]; m_cv = 0; m_halted = 0; m_ill = 0; m_pc = 1; m_err = 0; m_busy = 0;
   endtask

   task automatic model_edge();
      int op;
      op = int'(opcode);
      m_ill = 0;
      if (flush) begin
         m_ctrl = tab[0]; m_cv = 0; m_busy = 0;
         m_pc = !m_halted;
      end else if (stall) begin
      end else if (m_halted) begin
         if (resume) begin m_halted = 0; m_pc = 1; end
      end else if (m_busy > 0) begin
         m_busy--;
         m_pc = (m_busy == 0);
      end else begin
         m_ctrl = tab[0]; m_cv = 0; m_pc = 1;
         if (instr_valid) begin
            if (op == OPC_HALT) begin
               m_halted = 1; m_pc = 0;
            end else if (op > 15 || !legal[op]) begin
               m_ill = 1;
               m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
            end else begin
               m_ctrl = tab[op]; m_cv = 1;
               if (op == OPC_MAC) begin
                  m_busy = MAC_CYCLES - 1;
                  m_pc = (m_busy == 0);
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("ctrl_word", 32'({RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst,
                            ALUControl1, ALUControl2}), 32'(m_ctrl));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(m_cv));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("PCEn", 32'(PCEn), 32'(m_pc & ~stall));
   endtask

   task automatic step(input bit v, input int op, input bit st, input bit fl, input bit rs);
      @(negedge clk);
      instr_valid = v; opcode = OP_W'(op); stall = st; flush = fl; resume = rs;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < 16; i++) begin tab[i] = mk(0,1,0,0,0,0,7,7); legal[i] = 0; end
      tab[0]  = mk(0,1,0,0,0,0,7,7); legal[0]  = 1;
      tab[1]  = mk(1,1,0,0,0,1,0,7); legal[1]  = 1;
      tab[9]  = mk(1,1,0,0,1,0,0,7); legal[9]  = 1;
      tab[2]  = mk(1,1,0,0,0,1,1,7); legal[2]  = 1;
      tab[3]  = mk(1,1,0,0,0,1,2,7); legal[3]  = 1;
      tab[4]  = mk(1,1,0,0,0,1,1,0); legal[4]  = 1;
      tab[14] = mk(1,0,0,1,1,0,0,7); legal[14] = 1;
      tab[15] = mk(0,0,1,0,1,0,0,7); legal[15] = 1;
      legal[OPC_HALT] = 1;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      chk("rst_alu1", 32'(ALUControl1), 32'h7);
      @(negedge clk);
      reset_n = 1'b1;

      // LD then ST
      step(1, 14, 0, 0, 0);
      chk("ld_memread", 32'(MemRead), 32'h1);
      chk("ld_regdst", 32'(RegDst), 32'h0);
      step(1, 15, 0, 0, 0);
      chk("st_memwrite", 32'({MemWrite, RegWrite}), 32'h2);

      // MAC holds for two PCEn-low cycles, ADD presented throughout
      step(1, 4, 0, 0, 0);
      chk("mac_pc0", 32'(PCEn), 32'h0);
      step(1, 1, 0, 0, 0);
      chk("mac_pc1", 32'({PCEn, ALUControl1, ALUControl2}), 32'h08);
      step(1, 1, 0, 0, 0);
      chk("mac_done", 32'(PCEn), 32'h1);
      step(1, 1, 0, 0, 0);
      chk("add_after_mac", 32'({RegDst, ALUControl1}), 32'h8);

      // HALT / resume, and resume outside HALTED
      step(1, 11, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0);
      chk("halt_hold", 32'({halted, PCEn}), 32'h2);
      step(0, 0, 0, 0, 1);
      chk("resumed", 32'({halted, PCEn}), 32'h1);
      step(0, 0, 0, 0, 1);
      chk("resume_noop", 32'(halted), 32'h0);

      // Stall inside MAC_BUSY, flush inside MAC_BUSY, flush beating stall
      step(1, 4, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 4, 0, 0, 0);
      step(1, 2, 0, 1, 0);
      chk("flush_mac", 32'({ctrl_valid, o_dbg_state}), 32'h0);
      step(1, 2, 0, 0, 0);
      step(1, 3, 1, 1, 0);
      chk("flush_over_stall", 32'(ctrl_valid), 32'h0);

      // 300 illegal opcodes saturate the counter
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         step(1, 5, 0, 0, 0);
         if (illegal_op) pulses++;
      end
      chk("ill_pulses", 32'(pulses), 32'd300);
      chk("err_sat", 32'(err_count), 32'd255);
      step(1, 16, 0, 0, 0);
      chk("upper_bits_illegal", 32'(illegal_op), 32'h1);

      // Asynchronous reset in the middle of a MAC
      step(1, 4, 0, 0, 0);
      @(negedge clk);
      instr_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      reset_n = 1'b1;
      step(1, 9, 0, 0, 0);
      chk("first_after_rst", 32'(ALUSrc), 32'h1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int op;
         int legal_ops [9] = '{0, 1, 9, 2, 3, 4, 14, 15, 11};
         if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 8)];
         else op = int'($urandom_range(0, 31));
         step($urandom_range(0, 9) < 8, op, $urandom_range(0, 9) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
